// File: rtl/chip8_video_pkg.sv
// -----------------------------------------------------------------------------
// chip8_video_pkg
// Shared constants and types for the CHIP-8 framebuffer video path.
//   - 640x480@60 timing defaults and the derived line/frame totals (800/525)
//   - framebuffer geometry (64x32, 1 bit per pixel), 8x8 scale, window offsets
//   - 24-bit {R,G,B} colour type and the default colours
// -----------------------------------------------------------------------------
package chip8_video_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int FB_W           = 64;
    localparam int FB_H           = 32;
    localparam int COL_W          = 6;
    localparam int ROW_W          = 5;
    localparam int FB_ADDR_W      = ROW_W + COL_W;
    localparam int SCALE_LOG2_DEF = 3;
    localparam int H_WIN_OFS_DEF  = 64;
    localparam int V_WIN_OFS_DEF  = 112;

    // Wide enough for any practical h/v total.
    localparam int CNT_W = 12;

    typedef logic [23:0] rgb24_t;

    localparam rgb24_t FG_RGB_DEF     = 24'hFFFFFF;
    localparam rgb24_t BG_RGB_DEF     = 24'h000000;
    localparam rgb24_t BORDER_RGB_DEF = 24'h202020;

endpackage

// File: rtl/chip8_video_timing.sv
// -----------------------------------------------------------------------------
// chip8_video_timing
// Raster counters and stage-0 flags for the video path.
// Ports:
//   clk_25, reset_n      pixel clock, asynchronous active-low reset
//   h_cnt, v_cnt         current raster position (stage 0)
//   active               inside the visible area
//   window               inside the scaled framebuffer window
//   hs_n, vs_n           active-low syncs for the current position
//   frame_tick           registered one-cycle pulse, cycle after (h=0, v=V_ACTIVE)
// -----------------------------------------------------------------------------
module chip8_video_timing
    import chip8_video_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter int H_WIN_OFS = H_WIN_OFS_DEF,
    parameter int V_WIN_OFS = V_WIN_OFS_DEF,
    parameter int WIN_W     = FB_W << SCALE_LOG2_DEF,
    parameter int WIN_H     = FB_H << SCALE_LOG2_DEF
) (
    input  logic             clk_25,
    input  logic             reset_n,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             window,
    output logic             hs_n,
    output logic             vs_n,
    output logic             frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_WIN_BEG  = CNT_W'(H_WIN_OFS);
    localparam logic [CNT_W-1:0] H_WIN_END  = CNT_W'(H_WIN_OFS + WIN_W);
    localparam logic [CNT_W-1:0] V_WIN_BEG  = CNT_W'(V_WIN_OFS);
    localparam logic [CNT_W-1:0] V_WIN_END  = CNT_W'(V_WIN_OFS + WIN_H);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             frame_tick_q, frame_tick_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
        // First cycle of vertical blanking.
        frame_tick_d = (h_cnt_q == '0) && (v_cnt_q == V_ACT_END);
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign h_cnt      = h_cnt_q;
    assign v_cnt      = v_cnt_q;
    assign frame_tick = frame_tick_q;

    assign active = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    assign window = (h_cnt_q >= H_WIN_BEG) && (h_cnt_q < H_WIN_END) &&
                    (v_cnt_q >= V_WIN_BEG) && (v_cnt_q < V_WIN_END);
    assign hs_n   = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
    assign vs_n   = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));

endmodule

// File: rtl/chip8_fb_video_scaler.sv
// -----------------------------------------------------------------------------
// chip8_fb_video_scaler
// Displays the 64x32 CHIP-8 framebuffer on a 640x480@60 raster: each pixel is
// scaled to an 8x8 block and the 512x256 image is centred inside a border.
// Outputs lag the raster counters by 3 cycles; all outputs are mutually aligned.
// Ports:
//   clk_25, reset_n      pixel clock, asynchronous active-low reset
//   fb_addr, fb_rd_en    framebuffer read port {row[4:0], col[5:0]}
//   fb_rdata             pixel bit, valid one cycle after the read
//   vid_de/hs/vs/rgb     video out (syncs active-low, rgb = {R,G,B})
//   frame_tick           one-cycle pulse at the start of vertical blanking
// Build option:
//   CHIP8_SCANLINE_EN    halve FG/BG intensity on the last line of every cell
// -----------------------------------------------------------------------------
module chip8_fb_video_scaler
    import chip8_video_pkg::*;
#(
    parameter int     H_ACTIVE   = H_ACTIVE_DEF,
    parameter int     H_FP       = H_FP_DEF,
    parameter int     H_SYNC     = H_SYNC_DEF,
    parameter int     H_BP       = H_BP_DEF,
    parameter int     V_ACTIVE   = V_ACTIVE_DEF,
    parameter int     V_FP       = V_FP_DEF,
    parameter int     V_SYNC     = V_SYNC_DEF,
    parameter int     V_BP       = V_BP_DEF,
    parameter int     SCALE_LOG2 = SCALE_LOG2_DEF,
    parameter int     H_WIN_OFS  = H_WIN_OFS_DEF,
    parameter int     V_WIN_OFS  = V_WIN_OFS_DEF,
    parameter rgb24_t FG_RGB     = FG_RGB_DEF,
    parameter rgb24_t BG_RGB     = BG_RGB_DEF,
    parameter rgb24_t BORDER_RGB = BORDER_RGB_DEF
) (
    input  logic                 clk_25,
    input  logic                 reset_n,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic                 fb_rd_en,
    input  logic                 fb_rdata,
    output logic                 vid_de,
    output logic                 vid_hs,
    output logic                 vid_vs,
    output logic [23:0]          vid_rgb,
    output logic                 frame_tick
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             active, window, hs_n, vs_n;

    chip8_video_timing #(
        .H_ACTIVE  (H_ACTIVE),
        .H_FP      (H_FP),
        .H_SYNC    (H_SYNC),
        .H_BP      (H_BP),
        .V_ACTIVE  (V_ACTIVE),
        .V_FP      (V_FP),
        .V_SYNC    (V_SYNC),
        .V_BP      (V_BP),
        .H_WIN_OFS (H_WIN_OFS),
        .V_WIN_OFS (V_WIN_OFS),
        .WIN_W     (FB_W << SCALE_LOG2),
        .WIN_H     (FB_H << SCALE_LOG2)
    ) u_timing (
        .clk_25     (clk_25),
        .reset_n    (reset_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .window     (window),
        .hs_n       (hs_n),
        .vs_n       (vs_n),
        .frame_tick (frame_tick)
    );

    logic [CNT_W-1:0]     h_rel, v_rel;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic                 fb_rd_en_q, fb_rd_en_d;
    logic                 act_p1_q, act_p1_d, win_p1_q, win_p1_d;
    logic                 hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
    logic                 act_p2_q, act_p2_d, win_p2_q, win_p2_d;
    logic                 hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;
    logic                 vid_de_q, vid_de_d, vid_hs_q, vid_hs_d, vid_vs_q, vid_vs_d;
    rgb24_t               vid_rgb_q, vid_rgb_d;

    // ---- stage 0 -> 1: framebuffer address and flag capture ----
    always_comb begin
        h_rel      = h_cnt - CNT_W'(H_WIN_OFS);
        v_rel      = v_cnt - CNT_W'(V_WIN_OFS);
        fb_rd_en_d = window;
        // Address is only meaningful inside the window; hold it otherwise.
        fb_addr_d  = fb_addr_q;
        if (window) begin
            fb_addr_d = {ROW_W'(v_rel >> SCALE_LOG2), COL_W'(h_rel >> SCALE_LOG2)};
        end
        act_p1_d = active;
        win_p1_d = window;
        hs_p1_d  = hs_n;
        vs_p1_d  = vs_n;
    end

    // ---- stage 1 -> 2: read in flight, flags delayed to meet fb_rdata ----
    always_comb begin
        act_p2_d = act_p1_q;
        win_p2_d = win_p1_q;
        hs_p2_d  = hs_p1_q;
        vs_p2_d  = vs_p1_q;
    end

`ifdef CHIP8_SCANLINE_EN
    localparam logic [CNT_W-1:0] CELL_MASK = CNT_W'((1 << SCALE_LOG2) - 1);

    logic scan_p1_q, scan_p1_d, scan_p2_q, scan_p2_d;

    function automatic rgb24_t rgb_halve(input rgb24_t c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction

    always_comb begin
        scan_p1_d = window && ((v_rel & CELL_MASK) == CELL_MASK);
        scan_p2_d = scan_p1_q;
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            scan_p1_q <= 1'b0;
            scan_p2_q <= 1'b0;
        end else begin
            scan_p1_q <= scan_p1_d;
            scan_p2_q <= scan_p2_d;
        end
    end
`endif

    // ---- stage 2 -> out: colour select with fb_rdata ----
    always_comb begin
        vid_de_d  = act_p2_q;
        vid_hs_d  = hs_p2_q;
        vid_vs_d  = vs_p2_q;
        vid_rgb_d = '0;
        if (win_p2_q) begin
            vid_rgb_d = fb_rdata ? FG_RGB : BG_RGB;
`ifdef CHIP8_SCANLINE_EN
            if (scan_p2_q) begin
                vid_rgb_d = rgb_halve(vid_rgb_d);
            end
`endif
        end else if (act_p2_q) begin
            vid_rgb_d = BORDER_RGB;
        end
    end

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            fb_addr_q  <= '0;
            fb_rd_en_q <= 1'b0;
            act_p1_q   <= 1'b0;
            win_p1_q   <= 1'b0;
            hs_p1_q    <= 1'b1;
            vs_p1_q    <= 1'b1;
            act_p2_q   <= 1'b0;
            win_p2_q   <= 1'b0;
            hs_p2_q    <= 1'b1;
            vs_p2_q    <= 1'b1;
            vid_de_q   <= 1'b0;
            vid_hs_q   <= 1'b1;
            vid_vs_q   <= 1'b1;
            vid_rgb_q  <= '0;
        end else begin
            fb_addr_q  <= fb_addr_d;
            fb_rd_en_q <= fb_rd_en_d;
            act_p1_q   <= act_p1_d;
            win_p1_q   <= win_p1_d;
            hs_p1_q    <= hs_p1_d;
            vs_p1_q    <= vs_p1_d;
            act_p2_q   <= act_p2_d;
            win_p2_q   <= win_p2_d;
            hs_p2_q    <= hs_p2_d;
            vs_p2_q    <= vs_p2_d;
            vid_de_q   <= vid_de_d;
            vid_hs_q   <= vid_hs_d;
            vid_vs_q   <= vid_vs_d;
            vid_rgb_q  <= vid_rgb_d;
        end
    end

    assign fb_addr  = fb_addr_q;
    assign fb_rd_en = fb_rd_en_q;
    assign vid_de   = vid_de_q;
    assign vid_hs   = vid_hs_q;
    assign vid_vs   = vid_vs_q;
    assign vid_rgb  = vid_rgb_q;

endmodule

// File: tb/tb_chip8_fb_video_scaler.sv
// -----------------------------------------------------------------------------
// Bench for chip8_fb_video_scaler. Two instances share clock and reset:
//   u_def  full 640x480 timing, used for line-level timing and reset checks
//   u_sm   shrunken raster (136x68 visible, 2x scale, 4/2 offsets) so whole
//          frames fit in a short run
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_chip8_fb_video_scaler;

    localparam int S_HA = 136, S_HFP = 2, S_HSY = 4, S_HBP = 2;
    localparam int S_VA = 68,  S_VFP = 1, S_VSY = 2, S_VBP = 1;
    localparam int S_HT = S_HA + S_HFP + S_HSY + S_HBP;   // 144
    localparam int S_VT = S_VA + S_VFP + S_VSY + S_VBP;   // 72
    localparam int S_FRAME = S_HT * S_VT;                 // 10368
    localparam int S_XO = 4, S_YO = 2;
    localparam logic [23:0] FG = 24'hFFFFFF, BG = 24'h000000, BORDER = 24'h202020;

    logic clk_25 = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_25 = ~clk_25;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- default-timing instance ----------------
    logic [10:0] def_fb_addr;
    logic        def_fb_rd_en, def_fb_rdata;
    logic        def_vid_de, def_vid_hs, def_vid_vs, def_frame_tick;
    logic [23:0] def_vid_rgb;
    assign def_fb_rdata = 1'b1;

    chip8_fb_video_scaler u_def (
        .clk_25     (clk_25),
        .reset_n    (reset_n),
        .fb_addr    (def_fb_addr),
        .fb_rd_en   (def_fb_rd_en),
        .fb_rdata   (def_fb_rdata),
        .vid_de     (def_vid_de),
        .vid_hs     (def_vid_hs),
        .vid_vs     (def_vid_vs),
        .vid_rgb    (def_vid_rgb),
        .frame_tick (def_frame_tick)
    );

    // ---------------- small-timing instance ----------------
    logic [10:0] sm_fb_addr;
    logic        sm_fb_rd_en;
    logic        sm_fb_rdata = 1'b0;
    logic        sm_vid_de, sm_vid_hs, sm_vid_vs, sm_frame_tick;
    logic [23:0] sm_vid_rgb;

    chip8_fb_video_scaler #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HSY), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VSY), .V_BP (S_VBP),
        .SCALE_LOG2 (1), .H_WIN_OFS (S_XO), .V_WIN_OFS (S_YO)
    ) u_sm (
        .clk_25     (clk_25),
        .reset_n    (reset_n),
        .fb_addr    (sm_fb_addr),
        .fb_rd_en   (sm_fb_rd_en),
        .fb_rdata   (sm_fb_rdata),
        .vid_de     (sm_vid_de),
        .vid_hs     (sm_vid_hs),
        .vid_vs     (sm_vid_vs),
        .vid_rgb    (sm_vid_rgb),
        .frame_tick (sm_frame_tick)
    );

    // Framebuffer contents: 0 = only addr 0 lit, 1 = only addr 2047, 2 = all lit.
    int lit_mode = 0;

    function automatic logic lit(input int a, input int mode);
        case (mode)
            0:       return a == 0;
            1:       return a == 2047;
            default: return 1'b1;
        endcase
    endfunction

    // Synchronous read port; returns 1 when not read so stray use shows up.
    always @(posedge clk_25) begin
        sm_fb_rdata <= sm_fb_rd_en ? lit(int'(sm_fb_addr), lit_mode) : 1'b1;
    end

    // ---------------- reference model for the small raster ----------------
    function automatic logic in_win(input int x, input int y);
        return (x >= S_XO) && (x < S_XO + 128) && (y >= S_YO) && (y < S_YO + 64);
    endfunction

    function automatic int cell_addr(input int x, input int y);
        return (((y - S_YO) / 2) * 64) + ((x - S_XO) / 2);
    endfunction

    function automatic logic [23:0] exp_rgb(input int x, input int y, input int mode);
        logic [23:0] c;
        if (!((x < S_HA) && (y < S_VA))) return 24'h0;
        if (!in_win(x, y)) return BORDER;
        c = lit(cell_addr(x, y), mode) ? FG : BG;
`ifdef CHIP8_SCANLINE_EN
        if (((y - S_YO) % 2) == 1)
            c = {c[23:16] / 8'd2, c[15:8] / 8'd2, c[7:0] / 8'd2};
`endif
        return c;
    endfunction

    task automatic apply_reset();
        @(negedge clk_25);
        reset_n = 1'b0;
        repeat (3) @(negedge clk_25);
        reset_n = 1'b1;
    endtask

    logic [23:0] cap [0:S_VT-1][0:S_HT-1];
    int mism_px, mism_rd, mism_addr;

    // Runs one small-raster frame from reset, capturing every output pixel and
    // counting disagreements with the reference model.
    task automatic run_sm_frame();
        int x, y, q, p;
        logic [10:0] prev_addr;
        logic ede, ehs, evs;
        mism_px = 0; mism_rd = 0; mism_addr = 0;
        prev_addr = 11'd0;
        apply_reset();
        for (int k = 1; k <= S_FRAME + 2; k++) begin
            @(posedge clk_25); #1;
            q = (k - 1) % S_FRAME;
            x = q % S_HT; y = q / S_HT;
            if (sm_fb_rd_en !== in_win(x, y)) mism_rd++;
            else if (in_win(x, y) && (int'(sm_fb_addr) != cell_addr(x, y))) mism_addr++;
            else if (!in_win(x, y) && (sm_fb_addr !== prev_addr)) mism_addr++;
            prev_addr = sm_fb_addr;
            if (k >= 3) begin
                p = k - 3;
                x = p % S_HT; y = p / S_HT;
                ede = (x < S_HA) && (y < S_VA);
                ehs = !((x >= S_HA + S_HFP) && (x < S_HA + S_HFP + S_HSY));
                evs = !((y >= S_VA + S_VFP) && (y < S_VA + S_VFP + S_VSY));
                cap[y][x] = sm_vid_rgb;
                if ((sm_vid_rgb !== exp_rgb(x, y, lit_mode)) || (sm_vid_de !== ede) ||
                    (sm_vid_hs !== ehs) || (sm_vid_vs !== evs)) mism_px++;
            end else begin
                if ((sm_vid_de !== 1'b0) || (sm_vid_rgb !== 24'h0) ||
                    (sm_vid_hs !== 1'b1) || (sm_vid_vs !== 1'b1)) mism_px++;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk_25);
        reset_n = 1'b0;
        repeat (4) @(posedge clk_25);
        #1;
        n_checks++;
        if ({sm_vid_hs, sm_vid_vs, sm_vid_de} !== 3'b110) begin
            n_fail++; $display("FAIL reset_sync_de: got %b required 110", {sm_vid_hs, sm_vid_vs, sm_vid_de});
        end
        n_checks++;
        if (sm_vid_rgb !== 24'h0) begin
            n_fail++; $display("FAIL reset_rgb: got %h required 000000", sm_vid_rgb);
        end
        n_checks++;
        if ({sm_fb_rd_en, sm_fb_addr, sm_frame_tick} !== 13'h0) begin
            n_fail++; $display("FAIL reset_fb_tick: rd_en %b addr %h tick %b required 0", sm_fb_rd_en, sm_fb_addr, sm_frame_tick);
        end
        n_checks++;
        if ({def_vid_hs, def_vid_vs, def_vid_de, def_fb_rd_en} !== 4'b1100) begin
            n_fail++; $display("FAIL reset_def_flags: got %b required 1100", {def_vid_hs, def_vid_vs, def_vid_de, def_fb_rd_en});
        end
        // Run into the window, then drop reset between clock edges.
        @(negedge clk_25);
        reset_n = 1'b1;
        repeat (300) @(posedge clk_25);
        #1;
        n_checks++;
        if ({sm_fb_rd_en, sm_fb_addr, def_vid_de} !== {1'b1, 11'd3, 1'b1}) begin
            n_fail++; $display("FAIL midline_pre: rd_en %b addr %0d de %b required 1 3 1", sm_fb_rd_en, sm_fb_addr, def_vid_de);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({sm_fb_rd_en, sm_fb_addr} !== 12'h0) begin
            n_fail++; $display("FAIL async_fb: rd_en %b addr %0d required 0 0", sm_fb_rd_en, sm_fb_addr);
        end
        n_checks++;
        if ({def_vid_de, def_vid_hs, def_vid_vs, def_vid_rgb} !== {3'b011, 24'h0}) begin
            n_fail++; $display("FAIL async_video: de %b hs %b vs %b rgb %h required 0 1 1 000000", def_vid_de, def_vid_hs, def_vid_vs, def_vid_rgb);
        end
    endtask

    task automatic test_default_line();
        int first_de = -1, first_fall = -1, second_fall = -1, hs_rise = -1, de_fall = -1;
        int vs_low = 0, rd_hi = 0, ticks = 0;
        logic [23:0] rgb_first = 24'hx;
        logic de2 = 1'bx;
        logic p_hs = 1'b1, p_de = 1'b0;
        apply_reset();
        for (int k = 1; k <= 1700; k++) begin
            @(posedge clk_25); #1;
            if (k == 2) de2 = def_vid_de;
            if (def_vid_de && !p_de && first_de < 0) begin first_de = k; rgb_first = def_vid_rgb; end
            if (!def_vid_de && p_de && de_fall < 0) de_fall = k;
            if (!def_vid_hs && p_hs) begin
                if (first_fall < 0) first_fall = k; else if (second_fall < 0) second_fall = k;
            end
            if (def_vid_hs && !p_hs && hs_rise < 0) hs_rise = k;
            if (!def_vid_vs) vs_low++;
            if (def_fb_rd_en) rd_hi++;
            if (def_frame_tick) ticks++;
            p_hs = def_vid_hs; p_de = def_vid_de;
        end
        n_checks++;
        if (de2 !== 1'b0 || first_de != 3) begin
            n_fail++; $display("FAIL first_de: de@2 %b first de edge %0d required 0 and 3", de2, first_de);
        end
        n_checks++;
        if (rgb_first !== BORDER) begin
            n_fail++; $display("FAIL first_pixel_rgb: got %h required %h", rgb_first, BORDER);
        end
        n_checks++;
        if (de_fall - first_de != 640) begin
            n_fail++; $display("FAIL def_de_width: got %0d required 640", de_fall - first_de);
        end
        n_checks++;
        if (first_fall != 659) begin
            n_fail++; $display("FAIL def_hs_start: got %0d required 659", first_fall);
        end
        n_checks++;
        if (hs_rise - first_fall != 96) begin
            n_fail++; $display("FAIL def_hs_width: got %0d required 96", hs_rise - first_fall);
        end
        n_checks++;
        if (second_fall - first_fall != 800) begin
            n_fail++; $display("FAIL def_hs_period: got %0d required 800", second_fall - first_fall);
        end
        n_checks++;
        if (vs_low != 0 || rd_hi != 0 || ticks != 0) begin
            n_fail++; $display("FAIL def_top_lines: vs_low %0d rd_en %0d ticks %0d required 0 0 0", vs_low, rd_hi, ticks);
        end
    endtask

    task automatic test_timing_and_tick();
        int last_hs = -1, last_vs = -1, last_tick = -1, last_de = -1;
        int first_hs = -1, first_vs = -1, first_tick = -1;
        int hs_w_bad = 0, hs_p_bad = 0, vs_w_bad = 0, vs_p_bad = 0, de_w_bad = 0;
        int vs_falls = 0, lines_f = 0, ticks = 0, tick_wide = 0, tick_p_bad = 0;
        logic p_hs = 1'b1, p_vs = 1'b1, p_de = 1'b0, p_tick = 1'b0;
        lit_mode = 0;
        apply_reset();
        for (int k = 1; k <= 30600; k++) begin
            @(posedge clk_25); #1;
            if (!sm_vid_hs && p_hs) begin
                if (first_hs < 0) first_hs = k;
                else if (k - last_hs != S_HT) hs_p_bad++;
                last_hs = k;
            end
            if (sm_vid_hs && !p_hs && (k - last_hs != S_HSY)) hs_w_bad++;
            if (!sm_vid_vs && p_vs) begin
                if (first_vs < 0) first_vs = k;
                else if (k - last_vs != S_FRAME) vs_p_bad++;
                last_vs = k; vs_falls++;
            end
            if (sm_vid_vs && !p_vs && (k - last_vs != S_VSY * S_HT)) vs_w_bad++;
            if (sm_vid_de && !p_de) begin
                last_de = k;
                if (vs_falls == 1) lines_f++;
            end
            if (!sm_vid_de && p_de && (k - last_de != S_HA)) de_w_bad++;
            if (sm_frame_tick) begin
                if (p_tick) tick_wide++;
                else begin
                    ticks++;
                    if (first_tick < 0) first_tick = k;
                    else if (k - last_tick != S_FRAME) tick_p_bad++;
                    last_tick = k;
                end
            end
            p_hs = sm_vid_hs; p_vs = sm_vid_vs; p_de = sm_vid_de; p_tick = sm_frame_tick;
        end
        n_checks++;
        if (first_hs != 141 || hs_w_bad != 0 || hs_p_bad != 0) begin
            n_fail++; $display("FAIL sm_hs: first %0d width errs %0d period errs %0d required 141 0 0", first_hs, hs_w_bad, hs_p_bad);
        end
        n_checks++;
        if (first_vs != 9939 || vs_falls != 2) begin
            n_fail++; $display("FAIL sm_vs_pos: first %0d falls %0d required 9939 2", first_vs, vs_falls);
        end
        n_checks++;
        if (vs_w_bad != 0 || vs_p_bad != 0) begin
            n_fail++; $display("FAIL sm_vs_shape: width errs %0d period errs %0d required 0 0", vs_w_bad, vs_p_bad);
        end
        n_checks++;
        if (de_w_bad != 0 || lines_f != S_VA) begin
            n_fail++; $display("FAIL sm_de: width errs %0d lines %0d required 0 %0d", de_w_bad, lines_f, S_VA);
        end
        n_checks++;
        if (ticks != 3 || first_tick != 9793) begin
            n_fail++; $display("FAIL tick_count: pulses %0d first %0d required 3 9793", ticks, first_tick);
        end
        n_checks++;
        if (tick_wide != 0 || tick_p_bad != 0) begin
            n_fail++; $display("FAIL tick_shape: wide %0d spacing errs %0d required 0 0", tick_wide, tick_p_bad);
        end
    endtask

    task automatic test_map_first();
        int          sx [7] = '{4, 5, 6, 4, 3, 132, 10};
        int          sy [7] = '{2, 2, 2, 4, 2, 2, 70};
        logic [23:0] se [7] = '{FG, FG, BG, BG, BORDER, BORDER, 24'h0};
        lit_mode = 0;
        run_sm_frame();
        n_checks++;
        if (mism_px != 0) begin
            n_fail++; $display("FAIL map0_frame: %0d output cycles off model, required 0", mism_px);
        end
        n_checks++;
        if (mism_rd != 0 || mism_addr != 0) begin
            n_fail++; $display("FAIL map0_read: rd_en errs %0d addr errs %0d required 0 0", mism_rd, mism_addr);
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (cap[sy[i]][sx[i]] !== se[i]) begin
                n_fail++; $display("FAIL map0_px(%0d,%0d): got %h required %h", sx[i], sy[i], cap[sy[i]][sx[i]], se[i]);
            end
        end
    endtask

    task automatic test_map_last();
        int          sx [5] = '{130, 131, 129, 130, 130};
        int          sy [5] = '{64, 64, 64, 62, 66};
        logic [23:0] se [5] = '{FG, FG, BG, BG, BORDER};
        lit_mode = 1;
        run_sm_frame();
        n_checks++;
        if (mism_px != 0) begin
            n_fail++; $display("FAIL map_last_frame: %0d output cycles off model, required 0", mism_px);
        end
        n_checks++;
        if (mism_rd != 0 || mism_addr != 0) begin
            n_fail++; $display("FAIL map_last_read: rd_en errs %0d addr errs %0d required 0 0", mism_rd, mism_addr);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cap[sy[i]][sx[i]] !== se[i]) begin
                n_fail++; $display("FAIL last_px(%0d,%0d): got %h required %h", sx[i], sy[i], cap[sy[i]][sx[i]], se[i]);
            end
        end
    endtask

    task automatic test_scanline();
        int          sx [5] = '{4, 4, 10, 10, 2};
        int          sy [5] = '{3, 2, 65, 64, 3};
`ifdef CHIP8_SCANLINE_EN
        logic [23:0] se [5] = '{24'h7F7F7F, FG, 24'h7F7F7F, FG, BORDER};
`else
        logic [23:0] se [5] = '{FG, FG, FG, FG, BORDER};
`endif
        lit_mode = 2;
        run_sm_frame();
        n_checks++;
        if (mism_px != 0) begin
            n_fail++; $display("FAIL ones_frame: %0d output cycles off model, required 0", mism_px);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cap[sy[i]][sx[i]] !== se[i]) begin
                n_fail++; $display("FAIL ones_px(%0d,%0d): got %h required %h", sx[i], sy[i], cap[sy[i]][sx[i]], se[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_timing_and_tick();
        test_map_first();
        test_map_last();
        test_scanline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
